// File: rtl/ar_rxd_hub.sv
// ARINC-429 multi-channel receiver: per-channel word assembly, label filter,
// per-channel holding registers, round-robin arbiter, shared FWFT word FIFO.
//  state | meaning
//  IDLE  | waiting for the first bit edge of a word
//  RECV  | shifting bits in, timing the null gap that ends a word
//  CHECK | parity and label filter, hand word to the holding register
module ar_rxd_hub #(
   parameter int NCH        = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_CYC    = 1000
) (
   input  logic                        clk,
   input  logic                        R,
   input  logic [NCH-1:0]              inp1,
   input  logic [NCH-1:0]              inp0,
   input  logic                        filt_en,
   input  logic [7:0]                  filt_label,
   input  logic                        rd_en,
   output logic [7:0]                  rd_adr,
   output logic [23:0]                 rd_dat,
   output logic [2:0]                  rd_ch,
   output logic                        rd_perr,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        ce_wr,
   output logic [7:0]                  drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} ch_state_t;

   logic [NCH-1:0] s1_a, s1_b, s0_a, s0_b, act_q, act, edg;
   ch_state_t      st  [NCH];
   logic [5:0]     cnt [NCH];
   logic [GW-1:0]  gap [NCH];
   logic [31:0]    sh  [NCH];
   logic [7:0]     w_adr [NCH];
   logic [NCH-1:0] keep, drop;
   logic [3:0]     n_drop;
   logic [8:0]     drop_sum;
   // holding registers sized for 8 channels so a 3-bit grant can index them directly
   logic [7:0]     hold_v;
   logic [32:0]    hold_w [8];
   logic [2:0]     last, gnt;
   logic           gnt_v, wr, pop;
   logic [35:0]    mem [FIFO_DEPTH];
   logic [35:0]    head;
   logic [AW:0]    wr_ptr, rd_ptr;

   assign act = s1_b | s0_b;
   assign edg = act & ~act_q;

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NCH; i++) begin
         for (int k = 0; k < 8; k++) w_adr[i][7-k] = sh[i][k];
         keep[i] = (st[i] == CHECK) && (!filt_en || (w_adr[i] == filt_label));
         drop[i] = keep[i] && hold_v[i];
         n_drop  = n_drop + 4'(drop[i]);
      end
      drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
   end

   always_comb begin
      gnt   = '0;
      gnt_v = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         if (!gnt_v && hold_v[3'((int'(last) + k) % NCH)]) begin
            gnt   = 3'((int'(last) + k) % NCH);
            gnt_v = 1'b1;
         end
      end
   end

   assign wr    = gnt_v && !full;
   assign ce_wr = wr;
   assign pop   = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (!R) begin
         s1_a     <= '0;
         s1_b     <= '0;
         s0_a     <= '0;
         s0_b     <= '0;
         act_q    <= '0;
         hold_v   <= '0;
         last     <= 3'(NCH - 1);
         drop_cnt <= '0;
         for (int i = 0; i < NCH; i++) begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
            gap[i] <= '0;
            sh[i]  <= '0;
         end
         for (int i = 0; i < 8; i++) hold_w[i] <= '0;
      end else begin
         s1_a  <= inp1;
         s1_b  <= s1_a;
         s0_a  <= inp0;
         s0_b  <= s0_a;
         act_q <= act;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         if (wr) begin
            hold_v[gnt] <= 1'b0;
            last        <= gnt;
         end
         for (int i = 0; i < NCH; i++) begin
            case (st[i])
               IDLE: begin
                  if (edg[i] && !(s1_b[i] && s0_b[i])) begin
                     sh[i][0] <= s1_b[i];
                     cnt[i]   <= 6'd1;
                     gap[i]   <= '0;
                     st[i]    <= RECV;
                  end
               end
               RECV: begin
                  if (s1_b[i] && s0_b[i]) begin
                     st[i] <= IDLE;
                  end else if (edg[i]) begin
                     gap[i] <= '0;
                     if (cnt[i] == 6'd32) begin
                        st[i] <= IDLE;
                     end else begin
                        sh[i][cnt[i][4:0]] <= s1_b[i];
                        cnt[i]             <= cnt[i] + 6'd1;
                     end
                  end else if (!act[i]) begin
                     if (gap[i] == GW'(GAP_CYC - 1))
                        st[i] <= (cnt[i] == 6'd32) ? CHECK : IDLE;
                     else
                        gap[i] <= gap[i] + 1'b1;
                  end else begin
                     gap[i] <= '0;
                  end
               end
               CHECK: begin
                  st[i] <= IDLE;
                  if (keep[i] && !hold_v[i]) begin
                     hold_v[i] <= 1'b1;
                     hold_w[i] <= {~^sh[i], w_adr[i], sh[i][31:8]};
                  end
               end
               default: st[i] <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= {hold_w[gnt][32], gnt, hold_w[gnt][31:0]};
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(FIFO_DEPTH));
   // memory is not reset, so the head is forced to zero while empty
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign rd_perr = head[35];
   assign rd_ch   = head[34:32];
   assign rd_adr  = head[31:24];
   assign rd_dat  = head[23:0];
endmodule
